producer_fsm: RTL and testbench

PRODUCER_FSM -- requirements
Module: producer_fsm

---
 rtl/producer_pkg.sv | 21 ++
 rtl/word_fifo.sv | 78 +++++++
 rtl/producer_fsm.sv | 174 +++++++++++++++++
 tb/tb_producer_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/producer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : producer_pkg
//  Description : Shared widths and the handshake state encoding used by the
//                producer_fsm block and its word FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package producer_pkg;

    localparam int DATA_W = 16;  // width of a transmitted word
    localparam int CNT_W  = 8;   // width of sent_count and the timeout counter

    // Four-phase handshake states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage : producer_pkg
`default_nettype wire

// File: rtl/word_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : word_fifo
//  Description : Synchronous single-clock FIFO of DEPTH words.
//                A push while full is dropped; a pop while empty is ignored.
//                full is a function of the stored count only, so a push in
//                the same cycle as a pop from a full FIFO is still dropped.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push, push_data - write request and word
//                pop             - advance the read pointer
//                pop_data        - head word (valid when !empty)
//                full, empty     - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module word_fifo
    import producer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_DEPTH);
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Head word is read combinationally; the consumer registers it.
    assign pop_data = r_mem[r_rd_ptr];

    // Storage carries no reset: contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : word_fifo
`default_nettype wire

// File: rtl/producer_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : producer_fsm
//  Description : Word producer driving a four-phase send/inack handshake
//                from a DEPTH-word FIFO. Counts completed handshakes.
//                Optional REQ timeout enabled by macro PRODUCER_TIMEOUT_EN;
//                without it REQ waits forever and timeout_err is tied low.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                wr_en, wr_data   - FIFO write
//                full             - FIFO holds DEPTH words
//                send, data       - registered request and word to peripheral
//                inack            - peripheral acknowledge
//                busy             - FSM not idle or FIFO not empty
//                sent_count       - completed handshakes, modulo 256
//                timeout_err      - sticky handshake-timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module producer_fsm
    import producer_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              send,
    output logic [DATA_W-1:0] data,
    input  logic              inack,
    output logic              busy,
    output logic [CNT_W-1:0]  sent_count,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_data;
    logic               r_send;
    logic [CNT_W-1:0]   r_sent_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [DATA_W-1:0]  w_head;
    logic               w_pop;
    logic               w_send_nxt;
    logic               w_ack_done;
    logic               w_timeout;

    // ------------------------------------------------------------------
    // Send FIFO
    // ------------------------------------------------------------------
    word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Optional REQ timeout
    // ------------------------------------------------------------------
`ifdef PRODUCER_TIMEOUT_EN
    logic [CNT_W-1:0] r_to_cnt;
    logic             r_timeout_err;

    // r_to_cnt holds k during the k-th cycle spent in REQ, so the edge that
    // ends the TIMEOUT_CYCLES-th cycle is the one that abandons the word.
    assign w_timeout = (r_state == REQ) && !inack && (r_to_cnt == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_to_cnt <= CNT_W'(1);
            end else if (r_state == REQ && w_state_nxt == REQ) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign timeout_err      = 1'b0;
    assign w_unused_timeout = ^c_TIMEOUT;
`endif

    // ------------------------------------------------------------------
    // FSM: state register (plus registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_send       <= 1'b0;
            r_data       <= '0;
            r_sent_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_send  <= w_send_nxt;
            if (w_pop) begin
                r_data <= w_head;
            end
            if (w_ack_done) begin
                r_sent_count <= r_sent_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                // inack is deliberately ignored here.
                if (!w_fifo_empty) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // An ack arriving on the timeout edge takes precedence.
                if (inack) begin
                    w_state_nxt = RELEASE;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            RELEASE: begin
                if (!inack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_pop      = (r_state == IDLE) && !w_fifo_empty;
        w_ack_done = (r_state == RELEASE) && !inack;
        // send is exactly "the next state is REQ", registered.
        w_send_nxt = (w_state_nxt == REQ);
    end

    assign full       = w_fifo_full;
    assign send       = r_send;
    assign data       = r_data;
    assign sent_count = r_sent_count;
    assign busy       = (r_state != IDLE) || !w_fifo_empty;

endmodule : producer_fsm
`default_nettype wire

// File: tb/tb_producer_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_producer_fsm
//  Description : Directed, table-driven bench for producer_fsm (DEPTH=4,
//                TIMEOUT_CYCLES=10). Timeout scenario follows the
//                PRODUCER_TIMEOUT_EN macro of the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_producer_fsm;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        send;
    logic [15:0] data;
    logic        inack;
    logic        busy;
    logic [7:0]  sent_count;
    logic        timeout_err;

    int n_pass;
    int n_total;

    producer_fsm #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .send        (send),
        .data        (data),
        .inack       (inack),
        .busy        (busy),
        .sent_count  (sent_count),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [15:0] wd;
        logic        ack;
        logic        e_full;
        logic        e_send;
        logic [15:0] e_data;
        logic        e_busy;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic w, input logic [15:0] d,
                       input logic a, input logic ef, input logic es,
                       input logic [15:0] ed, input logic eb, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.wr = w; v.wd = d; v.ack = a;
        v.e_full = ef; v.e_send = es; v.e_data = ed; v.e_busy = eb; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    // Apply inputs just after an edge, clock once, sample 1 ns after the edge.
    task automatic step(input logic r, input logic w, input logic [15:0] d, input logic a);
        rst = r; wr_en = w; wr_data = d; inack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input vec_t v);
        n_total++;
        if ({full, send, data, busy, sent_count, timeout_err} ===
            {v.e_full, v.e_send, v.e_data, v.e_busy, v.e_cnt, 1'b0}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got full=%0b send=%0b data=%04h busy=%0b cnt=%0d err=%0b expected full=%0b send=%0b data=%04h busy=%0b cnt=%0d err=0",
                     name, full, send, data, busy, sent_count, timeout_err,
                     v.e_full, v.e_send, v.e_data, v.e_busy, v.e_cnt);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; inack = 1'b0;

        //   rst wr  wdata    ack | full send data     busy cnt
        // reset
        add(1, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 0);
        // single word: visible two edges after the write, ack 1 then 0
        add(0, 1, 16'h00A5, 0,   0, 0, 16'h0000, 1, 0);
        add(0, 0, 16'h0000, 0,   0, 1, 16'h00A5, 1, 0);
        add(0, 0, 16'h0000, 1,   0, 0, 16'h00A5, 1, 0);
        add(0, 0, 16'h0000, 0,   0, 0, 16'h00A5, 0, 1);
        // stray ack in IDLE with empty FIFO
        add(0, 0, 16'h0000, 1,   0, 0, 16'h00A5, 0, 1);
        add(0, 0, 16'h0000, 0,   0, 0, 16'h00A5, 0, 1);
        // burst: park in RELEASE (inack held) while filling the FIFO
        add(0, 1, 16'h0077, 0,   0, 0, 16'h00A5, 1, 1);
        add(0, 0, 16'h0000, 0,   0, 1, 16'h0077, 1, 1);
        add(0, 0, 16'h0000, 1,   0, 0, 16'h0077, 1, 1);
        add(0, 1, 16'h0001, 1,   0, 0, 16'h0077, 1, 1);
        add(0, 1, 16'h0002, 1,   0, 0, 16'h0077, 1, 1);
        add(0, 1, 16'h0003, 1,   0, 0, 16'h0077, 1, 1);
        add(0, 1, 16'h0004, 1,   1, 0, 16'h0077, 1, 1);
        add(0, 1, 16'h0005, 1,   1, 0, 16'h0077, 1, 1);  // dropped: full
        add(0, 0, 16'h0000, 0,   1, 0, 16'h0077, 1, 2);
        add(0, 1, 16'h0006, 0,   0, 1, 16'h0001, 1, 2);  // dropped: full before pop
        add(0, 0, 16'h0000, 1,   0, 0, 16'h0001, 1, 2);
        add(0, 0, 16'h0000, 0,   0, 0, 16'h0001, 1, 3);
        add(0, 0, 16'h0000, 0,   0, 1, 16'h0002, 1, 3);
        add(0, 0, 16'h0000, 1,   0, 0, 16'h0002, 1, 3);
        add(0, 0, 16'h0000, 0,   0, 0, 16'h0002, 1, 4);
        add(0, 0, 16'h0000, 0,   0, 1, 16'h0003, 1, 4);
        add(0, 0, 16'h0000, 1,   0, 0, 16'h0003, 1, 4);
        add(0, 0, 16'h0000, 0,   0, 0, 16'h0003, 1, 5);
        add(0, 0, 16'h0000, 0,   0, 1, 16'h0004, 1, 5);
        add(0, 0, 16'h0000, 1,   0, 0, 16'h0004, 1, 5);
        add(0, 0, 16'h0000, 0,   0, 0, 16'h0004, 0, 6);
        add(0, 0, 16'h0000, 0,   0, 0, 16'h0004, 0, 6);  // word 5/6 never appear

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].ack);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // ---------------- wrap: 256 handshakes from reset ----------------
        step(1, 0, 16'h0000, 0);
        for (int i = 0; i < 256; i++) begin
            step(0, 1, 16'(i + 16'h0100), 0);
            step(0, 0, 16'h0000, 0);
            if (i % 64 == 0) begin
                check("wrap_data", {15'd0, send, data}, {15'd0, 1'b1, 16'(i + 16'h0100)});
            end
            step(0, 0, 16'h0000, 1);
            step(0, 0, 16'h0000, 0);
            if (i == 254) begin
                check("wrap_cnt255", {24'd0, sent_count}, 32'd255);
            end
        end
        check("wrap_cnt0", {24'd0, sent_count}, 32'd0);

        // ---------------- reset mid-handshake ----------------
        step(0, 1, 16'h1234, 0);
        step(0, 1, 16'h2222, 0);   // pops 1234 into REQ
        step(0, 1, 16'h3333, 0);   // REQ, two words queued
        check("mid_req", {15'd0, send, data}, {15'd0, 1'b1, 16'h1234});
        step(1, 1, 16'h4444, 1);   // rst beats wr_en and inack
        check("mid_rst", {12'd0, full, send, busy, timeout_err, data, sent_count},
              {12'd0, 4'b0000, 16'h0000, 8'd0});
        step(0, 0, 16'h0000, 0);
        check("mid_after", {29'd0, send, busy, full}, 32'd0);
        check("mid_cnt", {24'd0, sent_count}, 32'd0);

`ifdef PRODUCER_TIMEOUT_EN
        // ---------------- timeout, TIMEOUT_CYCLES=10 ----------------
        step(0, 1, 16'hAAAA, 0);
        step(0, 1, 16'hBBBB, 0);   // enters REQ with AAAA (REQ cycle 1 begins)
        check("to_enter", {15'd0, send, data}, {15'd0, 1'b1, 16'hAAAA});
        for (int k = 1; k < 10; k++) begin
            step(0, 0, 16'h0000, 0);
            check($sformatf("to_hold%0d", k), {30'd0, send, timeout_err}, {30'd0, 2'b10});
        end
        step(0, 0, 16'h0000, 0);   // ends the 10th REQ cycle
        check("to_fire", {30'd0, send, timeout_err}, {30'd0, 2'b01});
        step(0, 0, 16'h0000, 0);
        check("to_next", {14'd0, send, timeout_err, data}, {14'd0, 2'b11, 16'hBBBB});
        // BBBB: ack arrives on the edge that would time out -> ack wins
        for (int k = 1; k < 10; k++) begin
            step(0, 0, 16'h0000, 0);
        end
        step(0, 0, 16'h0000, 1);
        check("to_ackwin", {29'd0, send, busy, timeout_err}, {29'd0, 3'b011});
        step(0, 0, 16'h0000, 0);
        check("to_cnt", {24'd0, sent_count}, 32'd1);
`else
        // ---------------- no timeout: REQ waits indefinitely ----------------
        step(0, 1, 16'hAAAA, 0);
        step(0, 0, 16'h0000, 0);
        check("nto_enter", {15'd0, send, data}, {15'd0, 1'b1, 16'hAAAA});
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 300; k++) begin
                step(0, 0, 16'h0000, 0);
                if (send !== 1'b1 || timeout_err !== 1'b0) bad++;
            end
            check("nto_hold300", bad, 0);
        end
        step(0, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 0);
        check("nto_done", {23'd0, send, timeout_err, sent_count}, {23'd0, 2'b00, 8'd1});
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_producer_fsm
`default_nettype wire
